// File: rtl/wb_sched.sv
// wb_sched: register-file writeback scheduler arbitrating ALU/link results against in-order load returns.
// Define WB_SCOREBOARD_EN to enable the per-register busy scoreboard and rd-based stalls.
module wb_sched #(
  parameter int LQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_link,
  input  logic [4:0]  ex_rd,
  output logic        ex_ready,
  input  logic        ld_issue_valid,
  input  logic [4:0]  ld_issue_rd,
  output logic        ld_issue_ready,
  input  logic        ld_rvalid,
  output logic [1:0]  wb_sel,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] busy_vec,
  output logic        lq_err
);

  localparam int PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam logic [PW:0]   DEPTH_C = (PW+1)'(LQ_DEPTH);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [1:0]    SEL_ALU = 2'b00;
  localparam logic [1:0]    SEL_MEM = 2'b01;
  localparam logic [1:0]    SEL_PC  = 2'b10;

  logic [4:0]    lq_mem_r [LQ_DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW:0]   count_r;

  logic          lq_empty_s;
  logic          lq_full_s;
  logic          push_s;
  logic          pop_s;
  logic          empty_ret_s;
  logic          ex_acc_s;
  logic [4:0]    pop_rd_s;
  logic          ld_busy_s;
  logic          ex_busy_s;

  assign lq_empty_s  = (count_r == {(PW+1){1'b0}});
  assign lq_full_s   = (count_r == DEPTH_C);
  assign pop_rd_s    = lq_mem_r[rd_ptr_r];
  // A return on an empty queue is an error and must never move a pointer.
  assign pop_s       = ld_rvalid && !lq_empty_s;
  assign empty_ret_s = ld_rvalid && lq_empty_s;

  // Handshake readies are pure functions of state and rd, never of the valids.
  always_comb begin
    ld_issue_ready = !lq_full_s && !ld_busy_s;
    ex_ready       = !ld_rvalid && !ex_busy_s;
  end

  assign push_s   = ld_issue_valid && ld_issue_ready;
  assign ex_acc_s = ex_valid && ex_ready;

`ifdef WB_SCOREBOARD_EN
  logic [31:0] busy_r;
  logic [31:0] busy_clr_s;
  logic [31:0] busy_set_s;

  assign ld_busy_s = busy_r[ld_issue_rd];
  assign ex_busy_s = busy_r[ex_rd];

  // Busy bit set/clear masks; x0 is never tracked.
  always_comb begin
    busy_clr_s = 32'h0000_0000;
    busy_set_s = 32'h0000_0000;
    if (pop_s) begin
      busy_clr_s[pop_rd_s] = 1'b1;
    end else begin
      busy_clr_s = 32'h0000_0000;
    end
    if (push_s && (ld_issue_rd != 5'd0)) begin
      busy_set_s[ld_issue_rd] = 1'b1;
    end else begin
      busy_set_s = 32'h0000_0000;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_r <= 32'h0000_0000;
    end else begin
      busy_r <= (busy_r & ~busy_clr_s) | busy_set_s;
    end
  end

  assign busy_vec = busy_r;
`else
  assign ld_busy_s = 1'b0;
  assign ex_busy_s = 1'b0;
  assign busy_vec  = 32'h0000_0000;
`endif

  // Load queue storage; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      lq_mem_r[wr_ptr_r] <= ld_issue_rd;
    end
  end

  // Queue pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {(PW+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Registered write port: load returns take priority over execute results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_sel   <= SEL_ALU;
      rf_we    <= 1'b0;
      rf_waddr <= 5'd0;
    end else if (pop_s) begin
      wb_sel   <= SEL_MEM;
      rf_waddr <= pop_rd_s;
      rf_we    <= (pop_rd_s != 5'd0);
    end else if (ex_acc_s) begin
      wb_sel   <= ex_link ? SEL_PC : SEL_ALU;
      rf_waddr <= ex_rd;
      rf_we    <= (ex_rd != 5'd0);
    end else begin
      rf_we    <= 1'b0;
    end
  end

  // Sticky error on a return with nothing outstanding.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lq_err <= 1'b0;
    end else if (empty_ret_s) begin
      lq_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_sched.sv
// tb_wb_sched: directed and random stimulus for wb_sched, checked against a queue-based reference model.
module tb_wb_sched;

  localparam int DEPTH = 4;
`ifdef WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_link;
  logic [4:0]  ex_rd;
  logic        ex_ready;
  logic        ld_issue_valid;
  logic [4:0]  ld_issue_rd;
  logic        ld_issue_ready;
  logic        ld_rvalid;
  logic [1:0]  wb_sel;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] busy_vec;
  logic        lq_err;

  int checks;
  int failures;

  logic [4:0]  q[$];
  logic        exp_we;
  logic [1:0]  exp_sel;
  logic [4:0]  exp_addr;
  logic        exp_err;
  logic [31:0] exp_busy;

  wb_sched #(.LQ_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_link(ex_link), .ex_rd(ex_rd), .ex_ready(ex_ready),
    .ld_issue_valid(ld_issue_valid), .ld_issue_rd(ld_issue_rd), .ld_issue_ready(ld_issue_ready),
    .ld_rvalid(ld_rvalid), .wb_sel(wb_sel), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .busy_vec(busy_vec), .lq_err(lq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_outputs();
    chk("rf_we", {31'd0, rf_we}, {31'd0, exp_we});
    chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, exp_addr});
    chk("wb_sel", {30'd0, wb_sel}, {30'd0, exp_sel});
    chk("busy_vec", busy_vec, exp_busy);
    chk("lq_err", {31'd0, lq_err}, {31'd0, exp_err});
  endtask

  // One clock of stimulus: check readies before the edge, outputs after it.
  task automatic step(input logic ev, input logic el, input logic [4:0] er,
                      input logic lv, input logic [4:0] lr, input logic rv);
    logic ld_rdy;
    logic ex_rdy;
    logic [4:0] r;
    ex_valid = ev; ex_link = el; ex_rd = er;
    ld_issue_valid = lv; ld_issue_rd = lr; ld_rvalid = rv;
    #1;
    ld_rdy = (q.size() < DEPTH) && !(SB && exp_busy[lr]);
    ex_rdy = !rv && !(SB && exp_busy[er]);
    chk("ld_issue_ready", {31'd0, ld_issue_ready}, {31'd0, ld_rdy});
    chk("ex_ready", {31'd0, ex_ready}, {31'd0, ex_rdy});
    if (rv) begin
      if (q.size() > 0) begin
        r = q.pop_front();
        exp_sel = 2'b01; exp_addr = r; exp_we = (r != 5'd0);
        exp_busy[r] = 1'b0;
      end else begin
        exp_err = 1'b1; exp_we = 1'b0;
      end
    end else if (ev && ex_rdy) begin
      exp_sel = el ? 2'b10 : 2'b00; exp_addr = er; exp_we = (er != 5'd0);
    end else begin
      exp_we = 1'b0;
    end
    if (lv && ld_rdy) begin
      q.push_back(lr);
      if (SB && lr != 5'd0) exp_busy[lr] = 1'b1;
    end
    @(posedge clk); #1;
    chk_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ex_valid = 1'b0; ex_link = 1'b0; ex_rd = 5'd0;
    ld_issue_valid = 1'b0; ld_issue_rd = 5'd0; ld_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    exp_we = 1'b0; exp_sel = 2'b00; exp_addr = 5'd0; exp_err = 1'b0; exp_busy = 32'd0;
    chk_outputs();
    chk("reset_ld_ready", {31'd0, ld_issue_ready}, 32'd1);
    chk("reset_ex_ready", {31'd0, ex_ready}, 32'd1);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    do_reset();

    // ALU and link writes, then an idle cycle holding sel/addr
    step(1'b1, 1'b0, 5'd5, 1'b0, 5'd0, 1'b0);
    step(1'b1, 1'b1, 5'd1, 1'b0, 5'd0, 1'b0);
    step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);

    // Fill the queue with ex_valid held high, then drain it
    step(1'b1, 1'b0, 5'd10, 1'b1, 5'd3, 1'b0);
    step(1'b1, 1'b0, 5'd10, 1'b1, 5'd4, 1'b0);
    step(1'b1, 1'b0, 5'd10, 1'b1, 5'd6, 1'b0);
    step(1'b1, 1'b0, 5'd10, 1'b1, 5'd7, 1'b0);
    step(1'b1, 1'b0, 5'd10, 1'b1, 5'd8, 1'b0);
    chk("full_count", q.size(), DEPTH);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 5'd10, 1'b0, 5'd0, 1'b1);
    step(1'b1, 1'b0, 5'd10, 1'b0, 5'd0, 1'b0);

    // Return with empty queue, error must stay sticky
    step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
    step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    step(1'b1, 1'b0, 5'd2, 1'b1, 5'd2, 1'b0);
    step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);

    // Rd 9 pending: busy, ex stall, refused duplicate load, release after return
    step(1'b0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0);
    step(1'b1, 1'b0, 5'd9, 1'b0, 5'd0, 1'b0);
    step(1'b1, 1'b0, 5'd9, 1'b1, 5'd9, 1'b0);
    if (!SB) step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
    step(1'b1, 1'b0, 5'd9, 1'b0, 5'd0, 1'b1);
    step(1'b1, 1'b0, 5'd9, 1'b0, 5'd0, 1'b0);
    step(1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0);
    step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);

    // Simultaneous issue/return at count 2 across pointer wraps
    step(1'b0, 1'b0, 5'd0, 1'b1, 5'd11, 1'b0);
    step(1'b0, 1'b0, 5'd0, 1'b1, 5'd12, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 5'd0, 1'b1, 5'(13 + i), 1'b1);
      chk("steady_count", q.size(), 2);
    end
    step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
    step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);

    // Loads outstanding at reset are discarded
    step(1'b0, 1'b0, 5'd0, 1'b1, 5'd20, 1'b0);
    step(1'b0, 1'b0, 5'd0, 1'b1, 5'd21, 1'b0);
    do_reset();
    step(1'b1, 1'b0, 5'd4, 1'b0, 5'd0, 1'b1);
    do_reset();

    // Random traffic with a mid-run reset
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      step(1'($urandom % 2), 1'($urandom % 2), 5'($urandom % 12),
           1'($urandom % 2), 5'($urandom % 12), 1'(($urandom % 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_sched.md
WB_SCHED -- requirements
Module: wb_sched

Interface
REQ-001 Parameter LQ_DEPTH, default 4, SHALL set the pending-load queue depth; legal values are powers of two from 2 to 16.
REQ-002 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1, SHALL be the synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 Port ex_valid, input, 1, SHALL indicate an execute-stage writeback request.
REQ-005 Port ex_link, input, 1, SHALL select the link (PC) source when 1 and the ALU source when 0.
REQ-006 Port ex_rd, input, 5, SHALL be the execute request destination register.
REQ-007 Port ex_ready, output, 1, SHALL accept the execute request when high together with ex_valid.
REQ-008 Port ld_issue_valid, input, 1, SHALL indicate a load issued to data memory.
REQ-009 Port ld_issue_rd, input, 5, SHALL be the load destination register.
REQ-010 Port ld_issue_ready, output, 1, SHALL accept the load issue when high together with ld_issue_valid.
REQ-011 Port ld_rvalid, input, 1, SHALL mark a data-memory return, in issue order.
REQ-012 Port wb_sel, output, 2, SHALL drive the result-mux select: 00 ALU, 01 memory data, 10 PC; 11 is never driven.
REQ-013 Port rf_we, output, 1, SHALL be the register-file write enable.
REQ-014 Port rf_waddr, output, 5, SHALL be the register-file write address.
REQ-015 Port busy_vec, output, 32, SHALL flag registers with an outstanding load.
REQ-016 Port lq_err, output, 1, SHALL be a sticky error flag.

Function
REQ-017 The block SHALL hold an in-order FIFO of pending load rd values; push on an accepted issue, pop on ld_rvalid.
REQ-018 ld_issue_ready SHALL equal (count < LQ_DEPTH), ANDed with !busy_vec[ld_issue_rd] when the scoreboard is enabled.
REQ-019 A simultaneous push and pop SHALL leave the count unchanged; pointers SHALL wrap modulo LQ_DEPTH.
REQ-020 ld_rvalid SHALL always win the write port; ex_ready SHALL be 0 in any cycle where ld_rvalid=1.
REQ-021 On ld_rvalid with a non-empty queue, the outputs in the next cycle SHALL be wb_sel=01, rf_waddr=popped rd, and rf_we=(rd!=0).
REQ-022 On an accepted ex request, the outputs in the next cycle SHALL be wb_sel=(ex_link?10:00), rf_waddr=ex_rd, and rf_we=(ex_rd!=0).
REQ-023 In a cycle with no accepted request and no return, the next-cycle outputs SHALL be rf_we=0 with wb_sel and rf_waddr holding their previous values.
REQ-024 Latency from acceptance to rf_we SHALL be exactly 1 cycle; all outputs except ex_ready and ld_issue_ready SHALL be registered.
REQ-025 ld_rvalid with an empty queue SHALL set lq_err, cause no write and no pointer change, and ignore the return.
REQ-026 ex_ready and ld_issue_ready SHALL be combinational and SHALL NOT depend on ex_valid or ld_issue_valid.

Reset
REQ-027 While rst_n=0 at a clock edge, the block SHALL clear the queue count and both pointers to 0.
REQ-028 The same reset SHALL set wb_sel=00, rf_we=0, rf_waddr=0, busy_vec=0 and lq_err=0.
REQ-029 Loads outstanding at reset SHALL be discarded; any ld_rvalid after reset SHALL be treated per REQ-025.

Configuration
REQ-030 With WB_SCOREBOARD_EN defined, the scoreboard SHALL be active:
- busy_vec[rd] set on load accept and cleared on the matching pop; x0 is never set.
- ex_ready additionally requires !busy_vec[ex_rd].
- A load issue to a busy rd SHALL be refused.
REQ-031 With WB_SCOREBOARD_EN undefined, busy_vec SHALL be constant 0 and no rd-based stalls SHALL occur; write-after-write ordering is then the issuer's responsibility.

Verification
REQ-032 Reset, then ex_valid=1, ex_link=0, ex_rd=5 -> next cycle rf_we=1, rf_waddr=5, wb_sel=00.
REQ-033 Link write: ex_link=1, ex_rd=1 -> next cycle wb_sel=10, rf_we=1, rf_waddr=1.
REQ-034 Queue fill and collision:
- Issue loads to rd 3, 4, 6, 7 -> ld_issue_ready=0 after the 4th.
- Four ld_rvalid pulses -> writes to 3, 4, 6, 7 in order with wb_sel=01.
- ex_valid held high throughout -> stalled during every return.
REQ-035 ld_rvalid with an empty queue -> lq_err=1, rf_we stays 0, and lq_err holds until reset.
REQ-036 WB_SCOREBOARD_EN defined, load to rd 9 pending:
- busy_vec[9]=1.
- ex_rd=9 -> ex_ready=0 until the cycle after the return.
- A load to rd 0 -> rf_we=0 on its return.
REQ-037 Simultaneous issue and return at count=2 -> count stays 2, and pointers wrap correctly across 10 such cycles.
